// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: load encodings, queue entry type and load data alignment/extension.
package wb_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] alo;
    } ld_ent_t;

    // LW and the undefined encodings fall through to the raw word.
    function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                                  input logic [1:0] alo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{alo, 3'b000} +: 8];
        h = alo[1] ? w[31:16] : w[15:0];
        return f3 == F3_LB  ? {{24{b[7]}}, b} :
               f3 == F3_LBU ? {24'b0, b} :
               f3 == F3_LH  ? {{16{h[15]}}, h} :
               f3 == F3_LHU ? {16'b0, h} : w;
    endfunction
endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: ALU, load issue, memory response and regfile write signals of the writeback stage.
interface wb_unit_if;
    import wb_unit_pkg::*;
    logic            clk_enable;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_issue_valid;
    logic            ld_issue_ready;
    logic [4:0]      ld_issue_rd;
    logic [2:0]      ld_issue_f3;
    logic [1:0]      ld_issue_alo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            w_en;
    logic [4:0]      w_sel;
    logic [XLEN-1:0] w_data;
    logic [31:0]     ld_busy;
    logic            err_unexp;

    modport master (
        output clk_enable, alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
               ld_issue_f3, ld_issue_alo, mem_rvalid, mem_rdata,
        input  alu_ready, ld_issue_ready, w_en, w_sel, w_data, ld_busy, err_unexp
    );
    modport slave (
        input  clk_enable, alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
               ld_issue_f3, ld_issue_alo, mem_rvalid, mem_rdata,
        output alu_ready, ld_issue_ready, w_en, w_sel, w_data, ld_busy, err_unexp
    );
endinterface

// File: rtl/wb_unit_ld_pending_fifo.sv
// ld_pending_fifo: in-order outstanding-load queue exposing every slot plus its valid mask.
module ld_pending_fifo import wb_unit_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  ld_ent_t           din_i,
    output ld_ent_t           head_o,
    output logic              full_o,
    output logic              empty_o,
    output ld_ent_t           ent_o [DEPTH],
    output logic [DEPTH-1:0]  valid_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ld_ent_t         mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
        if (!rst && push_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] off;
        assign off        = PW'(g) - rd_q;
        assign valid_o[g] = {1'b0, off} < cnt_q;
        assign ent_o[g]   = mem_q[g];
    end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage merging ALU results and in-order load responses into one
// registered regfile write, with a pending-load scoreboard for load-use stalls.
module wb_unit import wb_unit_pkg::*; #(
    parameter int LD_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    wb_unit_if.slave bus
);
    ld_ent_t            head, push_ent;
    ld_ent_t            ents [LD_DEPTH];
    logic [LD_DEPTH-1:0] vld;
    logic               full, empty, push, pop, alu_fire;
    logic               w_en_q, w_en_d, err_q, err_d;
    logic [4:0]         w_sel_q, w_sel_d;
    logic [XLEN-1:0]    w_data_q, w_data_d;
    logic [31:0]        busy;

    assign push_ent = '{rd: bus.ld_issue_rd, f3: bus.ld_issue_f3, alo: bus.ld_issue_alo};
    assign bus.ld_issue_ready = bus.clk_enable & ~full;
    assign bus.alu_ready      = bus.clk_enable & ~bus.mem_rvalid;
    assign push     = bus.ld_issue_valid & bus.ld_issue_ready;
    assign pop      = bus.clk_enable & bus.mem_rvalid & ~empty;
    assign alu_fire = bus.alu_valid & bus.alu_ready;

    ld_pending_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_ent),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .ent_o   (ents),
        .valid_o (vld)
    );

    // Load responses win the write port; the ALU is held off via alu_ready.
    always_comb begin
        w_en_d   = pop ? head.rd != '0 : alu_fire & (bus.alu_rd != '0);
        w_sel_d  = pop ? head.rd : alu_fire ? bus.alu_rd : w_sel_q;
        w_data_d = pop ? ld_extend(bus.mem_rdata, head.f3, head.alo) :
                   alu_fire ? bus.alu_data : w_data_q;
        err_d    = err_q | (bus.clk_enable & bus.mem_rvalid & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q   <= 1'b0;
            w_sel_q  <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else if (bus.clk_enable) begin
            w_en_q   <= w_en_d;
            w_sel_q  <= w_sel_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    // x0 never stalls issue, so its bit is forced low.
    always_comb begin
        busy = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (vld[i]) busy[ents[i].rd] = 1'b1;
        busy[0] = 1'b0;
    end

    assign bus.w_en      = w_en_q;
    assign bus.w_sel     = w_sel_q;
    assign bus.w_data    = w_data_q;
    assign bus.err_unexp = err_q;
    assign bus.ld_busy   = busy;
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] alo;
    } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ld_t         q[$];
    logic        m_en = 1'b0, m_err = 1'b0;
    logic [4:0]  m_sel = '0;
    logic [31:0] m_data = '0;

    wb_unit_if bus();
    wb_unit #(.LD_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] alo);
        logic [31:0] b, h;
        b = (d >> (8 * alo)) & 32'hFF;
        h = (d >> (16 * alo[1])) & 32'hFFFF;
        if (f3 == 3'd0) return b >= 128 ? b + 32'hFFFF_FF00 : b;
        if (f3 == 3'd4) return b;
        if (f3 == 3'd1) return h >= 32768 ? h + 32'hFFFF_0000 : h;
        if (f3 == 3'd5) return h;
        return d;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (q[i]) if (q[i].rd != 0) b = b | (32'd1 << q[i].rd);
        return b;
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        ld_t h;
        bit  push;
        #1;
        check("alu_ready", 32'(bus.alu_ready), 32'(bus.clk_enable && !bus.mem_rvalid));
        check("ld_issue_ready", 32'(bus.ld_issue_ready), 32'(bus.clk_enable && q.size() < DEPTH));
        check("ld_busy_pre", bus.ld_busy, model_busy());
        push = bus.clk_enable && bus.ld_issue_valid && q.size() < DEPTH;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_en = 0; m_sel = 0; m_data = 0; m_err = 0;
        end else if (bus.clk_enable) begin
            if (bus.mem_rvalid && q.size() > 0) begin
                h = q.pop_front();
                m_en = h.rd != 0; m_sel = h.rd; m_data = ext(bus.mem_rdata, h.f3, h.alo);
            end else if (bus.mem_rvalid) begin
                m_err = 1; m_en = 0;
            end else if (bus.alu_valid) begin
                m_en = bus.alu_rd != 0; m_sel = bus.alu_rd; m_data = bus.alu_data;
            end else m_en = 0;
            if (push) q.push_back('{bus.ld_issue_rd, bus.ld_issue_f3, bus.ld_issue_alo});
        end
        check("w_en", 32'(bus.w_en), 32'(m_en));
        check("w_sel", 32'(bus.w_sel), 32'(m_sel));
        check("w_data", bus.w_data, m_data);
        check("err_unexp", 32'(bus.err_unexp), 32'(m_err));
        check("ld_busy", bus.ld_busy, model_busy());
    endtask

    task automatic drive(input bit r, input bit ce, input bit av, input logic [4:0] ard,
                         input logic [31:0] ad, input bit lv, input logic [4:0] lrd,
                         input logic [2:0] lf3, input logic [1:0] lalo, input bit rv,
                         input logic [31:0] rdat);
        rst = r;
        bus.clk_enable = ce; bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.ld_issue_valid = lv; bus.ld_issue_rd = lrd; bus.ld_issue_f3 = lf3;
        bus.ld_issue_alo = lalo; bus.mem_rvalid = rv; bus.mem_rdata = rdat;
        step();
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
        drive(0, 1, 0, 0, 0, 1, rd, f3, alo, 0, 0);
    endtask

    task automatic resp(input logic [31:0] d);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_w_en", 32'(bus.w_en), 0);
        check("rst_w_data", bus.w_data, 0);
        check("rst_busy", bus.ld_busy, 0);

        // ALU only
        drive(0, 1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
        check("alu_sel5", 32'(bus.w_sel), 5);
        check("alu_data", bus.w_data, 32'h1234);
        drive(0, 1, 1, 0, 32'h5555, 0, 0, 0, 0, 0, 0);
        check("alu_rd0_en", 32'(bus.w_en), 0);

        // Extension
        issue(4, 0, 3); resp(32'h80FF_0000);
        check("lb", bus.w_data, 32'hFFFF_FF80);
        issue(4, 5, 2); resp(32'h80FF_0000);
        check("lhu", bus.w_data, 32'h0000_80FF);
        issue(4, 1, 0); resp(32'h0000_8001);
        check("lh", bus.w_data, 32'hFFFF_8001);
        issue(4, 2, 0); resp(32'h80FF_0000);
        check("lw", bus.w_data, 32'h80FF_0000);

        // Conflict: load response beats ALU
        issue(7, 2, 0);
        drive(0, 1, 1, 3, 32'hABCD, 0, 0, 0, 0, 1, 32'h77);
        check("conf_sel", 32'(bus.w_sel), 7);
        drive(0, 1, 1, 3, 32'hABCD, 0, 0, 0, 0, 0, 0);
        check("conf_alu", 32'(bus.w_sel), 3);

        // Queue fill/drain, three rounds to wrap pointers
        for (int k = 0; k < 3; k++) begin
            issue(1, 2, 0); issue(2, 2, 0); issue(2, 2, 0); issue(9, 2, 0);
            idle();
            check("full_rdy", 32'(bus.ld_issue_ready), 0);
            check("busy4", bus.ld_busy, 32'h206);
            resp(32'h11); resp(32'h22);
            check("busy2", bus.ld_busy, 32'h204);
            resp(32'h33); resp(32'h44);
            check("busy0", bus.ld_busy, 0);
            idle();
            check("empty_rdy", 32'(bus.ld_issue_ready), 1);
        end

        // Unexpected response, then reset with loads queued
        resp(32'hDEAD);
        check("unexp_err", 32'(bus.err_unexp), 1);
        check("unexp_wen", 32'(bus.w_en), 0);
        issue(6, 2, 0); issue(8, 2, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_busy2", bus.ld_busy, 0);
        check("rst_err", 32'(bus.err_unexp), 0);
        resp(32'h1);
        check("late_err", 32'(bus.err_unexp), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Halt holds everything
        issue(12, 2, 0);
        drive(0, 1, 1, 10, 32'hCAFE, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 11, 32'hBEEF, 1, 13, 2, 0, 0, 0);
        check("halt_sel", 32'(bus.w_sel), 10);
        check("halt_busy", bus.ld_busy, 32'h1000);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit ce, rv;
            ce = ($urandom % 8) != 0;
            rv = ce && (q.size() > 0 ? ($urandom % 2) == 1 : ($urandom % 64) == 0);
            drive(($urandom % 500) == 0, ce, $urandom % 2, 5'($urandom), $urandom,
                  $urandom % 2, 5'($urandom % 16), 3'($urandom), 2'($urandom), rv, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
